alimentador_filtro: RTL and testbench
=====================================

// Module: alimentador_filtro
// PURPOSE
//  Sample feeder (write side) for the filter peripheral. Buffers CPU-written samples in a FIFO.
//  Delivers them to the filter core over a valid/ready stream, in batches of BATCH samples.
//  Pulses cuente per delivered sample and batch_done per completed batch.
//  After each batch, inserts GAP_CYCLES idle cycles so the filter core can compute.
// PARAMETERS
//  DATA_W      16  sample width, bits
//  DEPTH       16  FIFO entries, power of two, >=2
//  BATCH        9  samples per batch, >=2
//  GAP_CYCLES   4  idle cycles after each batch, >=1
// PORTS
//  clk         in   1                     clock, all logic on posedge
//  rst         in   1                     reset, synchronous, active-high
//  we          in   1                     bus write strobe, push wdata
//  wdata       in   DATA_W                sample to push
//  flush       in   1                     sync clear of FIFO and batch position
//  clr_ovf     in   1                     clears overflow flag
//  full        out  1                     FIFO holds DEPTH entries
//  level       out  $clog2(DEPTH+1)       current FIFO occupancy
//  overflow    out  1                     sticky: write dropped while full
//  out_valid   out  1                     out_data valid toward filter core
//  out_ready   in   1                     filter core accepts out_data
//  out_data    out  DATA_W                FIFO head sample
//  cuente      out  1                     high in the cycle of each transfer
//  batch_idx   out  $clog2(BATCH)         samples already delivered in current batch
//  batch_done  out  1                     one-cycle pulse, cycle after last transfer of a batch
// BEHAVIOUR
//  - Reset: FIFO empty, all pointers 0, level=0, full=0, overflow=0, out_valid=0, cuente=0.
//    Also batch_idx=0, batch_done=0, state=IDLE, gap counter 0.
//  - Priority: rst > flush > normal operation.
//  - flush: empties FIFO, batch_idx<=0, state<=IDLE, gap counter cleared.
//    A write in the same cycle as flush is discarded. overflow is unchanged by flush.
//  - Push: we && !full -> store wdata; level +1 next cycle.
//  - we && full -> sample dropped, overflow<=1.
//    full is judged on the current level, so a pop in the same cycle does not admit the write.
//  - clr_ovf clears overflow. If clr_ovf and a dropped write occur in the same cycle, overflow stays 1.
//  - Transfer = out_valid && out_ready. Pop on transfer.
//    Simultaneous push and pop leaves level unchanged.
//  - out_data = FIFO head (first-word fall-through). Stable while out_valid && !out_ready.
//  - Latency: a sample written into an empty FIFO at cycle N gives out_valid=1 at N+1 (state SEND).
//  - out_valid = (state==SEND) && level!=0. It is never high in IDLE or GAP.
//  - cuente = transfer (combinational, same cycle as the transfer).
//  - FSM:
//     IDLE: level==0. Go to SEND when level!=0.
//     SEND: on transfer with batch_idx==BATCH-1: batch_idx<=0, batch_done<=1, load gap counter with GAP_CYCLES, go to GAP.
//           On any other transfer: batch_idx+1.
//           If the FIFO drains mid-batch: go to IDLE, batch_idx retained (batch resumes on next sample).
//     GAP:  decrement gap counter each cycle; writes are still accepted.
//           When the counter reaches 0: go to SEND if level!=0, else IDLE.
//           The gap lasts exactly GAP_CYCLES cycles with out_valid=0.
//  - batch_done is high for one cycle only, the first GAP cycle.
//  - Pointers wrap modulo DEPTH. level saturates at DEPTH. The FIFO never pops when empty.
// TESTING
//  1. rst held 2 cycles -> level=0, out_valid=0, overflow=0, batch_idx=0, batch_done=0.
//  2. Write 9 samples 0x0001..0x0009 with out_ready=1 -> 9 cuente pulses, data 1..9 in order.
//     Then batch_done pulses once and out_valid=0 for exactly 4 cycles.
//  3. Write 18 samples, out_ready=1 -> two batches of 9, separated by a 4-cycle gap.
//     batch_idx sequence 0..8, 0..8.
//  4. out_ready=0 and 17 writes -> full=1 after 16, the 17th write is dropped and overflow=1.
//     clr_ovf -> overflow=0. Then out_ready=1 -> first 9 of samples 1..16 delivered, then a 4-cycle gap.
//  5. Write 5 samples, drain, wait 3 cycles idle, write 4 more -> batch_done after the 9th transfer overall.
//  6. flush after 4 of 9 transfers, write 9 new samples -> full batch of 9, level=0 right after flush, overflow unchanged.

Source files
------------

// File: rtl/alimentador_filtro_if.sv
// Bus-side and stream-side signals of the sample feeder, grouped for the CPU/test driver
// (master) and the feeder itself (slave). Prefixes are from the feeder's point of view.
interface alimentador_filtro_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int BATCH  = 9
);
  logic                         i_we;
  logic [DATA_W-1:0]            i_wdata;
  logic                         i_flush;
  logic                         i_clr_ovf;
  logic                         i_out_ready;
  logic                         o_full;
  logic [$clog2(DEPTH+1)-1:0]   o_level;
  logic                         o_overflow;
  logic                         o_out_valid;
  logic [DATA_W-1:0]            o_out_data;
  logic                         o_cuente;
  logic [$clog2(BATCH)-1:0]     o_batch_idx;
  logic                         o_batch_done;

  modport master (
    output i_we, i_wdata, i_flush, i_clr_ovf, i_out_ready,
    input  o_full, o_level, o_overflow, o_out_valid, o_out_data,
           o_cuente, o_batch_idx, o_batch_done
  );

  modport slave (
    input  i_we, i_wdata, i_flush, i_clr_ovf, i_out_ready,
    output o_full, o_level, o_overflow, o_out_valid, o_out_data,
           o_cuente, o_batch_idx, o_batch_done
  );
endinterface

// File: rtl/alimentador_filtro.sv
// Sample feeder: FIFO of CPU-written samples delivered to the filter core in batches,
// with a fixed idle gap after each batch so the core can compute.
module alimentador_filtro #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 16,
  parameter int BATCH      = 9,
  parameter int GAP_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  alimentador_filtro_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int IW = $clog2(BATCH);
  localparam int GW = $clog2(GAP_CYCLES+1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [LW-1:0]     r_level;
  logic              r_ovf;
  state_t            r_state, w_next;
  logic [IW-1:0]     r_idx;
  logic              r_done;
  logic [GW-1:0]     r_gap;

  logic              w_full, w_push, w_pop, w_valid, w_last;
  logic [LW-1:0]     w_level_nxt;

  // full is judged on the current level: a same-cycle pop never admits a write
  assign w_full      = (r_level == LW'(DEPTH));
  assign w_push      = bus.i_we && !w_full && !bus.i_flush;
  assign w_pop       = w_valid && bus.i_out_ready;
  assign w_last      = (r_idx == IW'(BATCH-1));
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  // sample storage, no reset needed: only entries below level are ever observed
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr] <= bus.i_wdata;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || bus.i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
    end
  end

  // sticky overflow; a dropped write wins over a same-cycle clear, flush leaves it alone
  always_ff @(posedge clk) begin
    if (rst)                          r_ovf <= 1'b0;
    else if (bus.i_we && w_full)      r_ovf <= 1'b1;
    else if (bus.i_clr_ovf)           r_ovf <= 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst || bus.i_flush) r_state <= S_IDLE;
    else                    r_state <= w_next;
  end

  // FSM next state; uses next-cycle level so a fresh write is offered one cycle later
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_level_nxt != '0) w_next = S_SEND;
      S_SEND: begin
        if (w_pop && w_last)          w_next = S_GAP;
        else if (w_level_nxt == '0)   w_next = S_IDLE;
      end
      S_GAP:  if (r_gap == GW'(1))    w_next = (w_level_nxt != '0) ? S_SEND : S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
  end

  // FSM outputs: stream valid only while sending with data available
  always_comb begin
    w_valid = (r_state == S_SEND) && (r_level != '0);
  end

  // batch position, batch-done pulse and gap countdown
  always_ff @(posedge clk) begin
    if (rst || bus.i_flush) begin
      r_idx  <= '0;
      r_done <= 1'b0;
      r_gap  <= '0;
    end else begin
      r_done <= w_pop && w_last;
      if (w_pop) r_idx <= w_last ? '0 : r_idx + IW'(1);
      if (w_pop && w_last)                         r_gap <= GW'(GAP_CYCLES);
      else if (r_state == S_GAP && r_gap != '0)    r_gap <= r_gap - GW'(1);
    end
  end

  assign bus.o_full       = w_full;
  assign bus.o_level      = r_level;
  assign bus.o_overflow   = r_ovf;
  assign bus.o_out_valid  = w_valid;
  assign bus.o_out_data   = r_mem[r_rptr];
  assign bus.o_cuente     = w_pop;
  assign bus.o_batch_idx  = r_idx;
  assign bus.o_batch_done = r_done;
endmodule

// File: tb/tb_alimentador_filtro.sv
// Directed bench for the sample feeder: vector table for streaming batches,
// hand sequences for overflow, mid-batch drain and flush.
module tb_alimentador_filtro;
  localparam int DATA_W = 16, DEPTH = 16, BATCH = 9, GAP_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alimentador_filtro_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BATCH(BATCH)) bus_if ();

  alimentador_filtro #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BATCH(BATCH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .bus(bus_if)
  );

  typedef struct {
    logic        we;
    logic [15:0] wd;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic        ec;
    logic [4:0]  el;
    logic [3:0]  ei;
    logic        edone;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(logic we, logic [15:0] wd, logic ev, logic [15:0] ed,
                              logic [4:0] el, logic [3:0] ei, logic edone);
    vec_t v;
    v.we = we; v.wd = wd; v.rdy = 1'b1; v.ev = ev; v.ed = ed; v.ec = ev;
    v.el = el; v.ei = ei; v.edone = edone;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [15:0] wd, input logic rdy);
    bus_if.i_we = we; bus_if.i_wdata = wd; bus_if.i_out_ready = rdy;
  endtask

  initial begin
    drive(1'b0, 16'h0, 1'b0);
    bus_if.i_flush = 1'b0; bus_if.i_clr_ovf = 1'b0;

    // streaming batch of 9, then two back-to-back batches of 9
    add(1, 16'd1, 0, 0, 0, 0, 0);
    for (int t = 1; t <= 8; t++) add(1, 16'(t+1), 1, 16'(t), 1, 4'(t-1), 0);
    add(0, 0, 1, 16'd9, 1, 4'd8, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    for (int t = 11; t <= 14; t++) add(0, 0, 0, 0, 0, 0, 0);

    for (int t = 0; t <= 27; t++) begin
      logic        we;
      logic [15:0] wd;
      we = (t <= 17);
      wd = we ? 16'(t+1) : 16'h0;
      if (t == 0)        add(we, wd, 0, 0, 0, 0, 0);
      else if (t <= 9)   add(we, wd, 1, 16'(t), 1, 4'(t-1), 0);
      else if (t <= 13)  add(we, wd, 0, 0, 5'(t-9), 0, t == 10);
      else if (t <= 22)  add(we, wd, 1, 16'(t-4), (t <= 18) ? 5'd5 : 5'(23-t), 4'(t-14), 0);
      else               add(we, wd, 0, 0, 0, 0, t == 23);
    end

    // reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #4;
    chk("rst_level", bus_if.o_level, 0);
    chk("rst_valid", bus_if.o_out_valid, 0);
    chk("rst_ovf", bus_if.o_overflow, 0);
    chk("rst_idx", bus_if.o_batch_idx, 0);
    chk("rst_done", bus_if.o_batch_done, 0);
    chk("rst_full", bus_if.o_full, 0);
    tick();

    // table vectors
    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].wd, tbl[i].rdy);
      #4;
      chk($sformatf("v%0d_valid", i), bus_if.o_out_valid, tbl[i].ev);
      chk($sformatf("v%0d_cuente", i), bus_if.o_cuente, tbl[i].ec);
      chk($sformatf("v%0d_level", i), bus_if.o_level, tbl[i].el);
      chk($sformatf("v%0d_idx", i), bus_if.o_batch_idx, tbl[i].ei);
      chk($sformatf("v%0d_done", i), bus_if.o_batch_done, tbl[i].edone);
      if (tbl[i].ev) chk($sformatf("v%0d_data", i), bus_if.o_out_data, tbl[i].ed);
      tick();
    end
    drive(1'b0, 16'h0, 1'b0);

    // fill to full with core stalled, drop the 17th write
    for (int i = 1; i <= 16; i++) begin drive(1'b1, 16'(i), 1'b0); tick(); end
    drive(1'b1, 16'd17, 1'b0);
    #4;
    chk("ful_full", bus_if.o_full, 1);
    chk("ful_level", bus_if.o_level, 16);
    chk("ful_valid", bus_if.o_out_valid, 1);
    chk("ful_cuente", bus_if.o_cuente, 0);
    chk("ful_data", bus_if.o_out_data, 1);
    chk("ful_ovf0", bus_if.o_overflow, 0);
    tick();
    drive(1'b1, 16'd18, 1'b0);
    bus_if.i_clr_ovf = 1'b1;
    #4;
    chk("drop_ovf", bus_if.o_overflow, 1);
    chk("drop_level", bus_if.o_level, 16);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    #4;
    chk("clrdrop_ovf", bus_if.o_overflow, 1);
    tick();
    bus_if.i_clr_ovf = 1'b0;
    #4;
    chk("clr_ovf", bus_if.o_overflow, 0);
    chk("stall_data", bus_if.o_out_data, 1);
    tick();
    drive(1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      #4;
      chk($sformatf("b4_valid%0d", k), bus_if.o_out_valid, 1);
      chk($sformatf("b4_data%0d", k), bus_if.o_out_data, k+1);
      chk($sformatf("b4_idx%0d", k), bus_if.o_batch_idx, k);
      tick();
    end
    for (int g = 0; g < 4; g++) begin
      #4;
      chk($sformatf("b4_gapv%0d", g), bus_if.o_out_valid, 0);
      chk($sformatf("b4_gapd%0d", g), bus_if.o_batch_done, g == 0);
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      #4;
      chk($sformatf("b4_rest%0d", k), bus_if.o_out_data, k+10);
      chk($sformatf("b4_ridx%0d", k), bus_if.o_batch_idx, k);
      tick();
    end
    #4;
    chk("b4_drain_valid", bus_if.o_out_valid, 0);
    chk("b4_drain_level", bus_if.o_level, 0);
    chk("b4_keep_idx", bus_if.o_batch_idx, 7);
    tick();
    bus_if.i_flush = 1'b1;
    tick();
    bus_if.i_flush = 1'b0;
    #4;
    chk("b4_flush_idx", bus_if.o_batch_idx, 0);
    tick();

    // 5 samples, drain, idle, 4 more: batch completes on 9th transfer overall
    for (int c = 0; c <= 5; c++) begin
      drive(c < 5, 16'(c+1), 1'b1);
      #4;
      if (c == 0) chk("p5_first_valid", bus_if.o_out_valid, 0);
      else begin
        chk($sformatf("p5_data%0d", c), bus_if.o_out_data, c);
        chk($sformatf("p5_idx%0d", c), bus_if.o_batch_idx, c-1);
      end
      tick();
    end
    drive(1'b0, 16'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #4;
      chk($sformatf("p5_idle_v%0d", c), bus_if.o_out_valid, 0);
      chk($sformatf("p5_idle_i%0d", c), bus_if.o_batch_idx, 5);
      tick();
    end
    for (int c = 0; c <= 5; c++) begin
      drive(c < 4, 16'(c+6), 1'b1);
      #4;
      if (c == 0) chk("p5b_valid", bus_if.o_out_valid, 0);
      else if (c <= 4) begin
        chk($sformatf("p5b_data%0d", c), bus_if.o_out_data, c+5);
        chk($sformatf("p5b_idx%0d", c), bus_if.o_batch_idx, c+4);
        chk($sformatf("p5b_nd%0d", c), bus_if.o_batch_done, 0);
      end else begin
        chk("p5b_done", bus_if.o_batch_done, 1);
        chk("p5b_gapv", bus_if.o_out_valid, 0);
      end
      tick();
    end
    drive(1'b0, 16'h0, 1'b0);
    repeat (4) tick();

    // flush mid-batch with overflow set, then a clean batch of 9
    for (int i = 1; i <= 17; i++) begin drive(1'b1, 16'(i), 1'b0); tick(); end
    drive(1'b0, 16'h0, 1'b0);
    #4;
    chk("f6_ovf", bus_if.o_overflow, 1);
    chk("f6_full", bus_if.o_full, 1);
    tick();
    drive(1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #4;
      chk($sformatf("f6_data%0d", k), bus_if.o_out_data, k+1);
      chk($sformatf("f6_idx%0d", k), bus_if.o_batch_idx, k);
      tick();
    end
    drive(1'b1, 16'hDEAD, 1'b0);
    bus_if.i_flush = 1'b1;
    tick();
    bus_if.i_flush = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    #4;
    chk("f6_level", bus_if.o_level, 0);
    chk("f6_idx", bus_if.o_batch_idx, 0);
    chk("f6_ovf_kept", bus_if.o_overflow, 1);
    chk("f6_valid", bus_if.o_out_valid, 0);
    chk("f6_full0", bus_if.o_full, 0);
    tick();
    for (int c = 0; c <= 10; c++) begin
      drive(c < 9, 16'h100 + 16'(c), 1'b1);
      #4;
      if (c >= 1 && c <= 9) begin
        chk($sformatf("f6b_data%0d", c), bus_if.o_out_data, 16'h100 + c - 1);
        chk($sformatf("f6b_idx%0d", c), bus_if.o_batch_idx, c-1);
        chk($sformatf("f6b_cu%0d", c), bus_if.o_cuente, 1);
      end else if (c == 10) begin
        chk("f6b_done", bus_if.o_batch_done, 1);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
